// File: rtl/video_to_fifo_ctrl.sv
// rtl/video_to_fifo_ctrl.sv - DE-framed RGB video packer feeding the AXI write FIFO
//
// Packs AXI4_DATA_WIDTH/32 pixels per FIFO word, first pixel in the MSB lane
// (lane = {8'h00, rgb}). Raises one burst request per completed line of
// BURST_BEATS words so the AXI writer moves one line at a time.
//
// Optional feature macro: VIDEO_TO_FIFO_TEST_PATTERN_EN replaces the pixel
// with {x[7:0], y[7:0], frame[7:0]}, framing still taken from vs/de.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   video_vs_in/de_in/data_in   video input, synchronous to M_AXI_ACLK
//   fifo_data_out, fifo_wr_en   packed word and its one-cycle write strobe
//   fifo_full                   FIFO full; a word hitting it is dropped
//   AXI_FULL_BURST_VALID/READY  line-burst request handshake
//   frame_start                 one-cycle pulse after VS falling edge
//   err_overflow, err_line      sticky error flags, cleared by reset only
module video_to_fifo_ctrl #(
  parameter int H_DISP          = 1920,
  parameter int V_DISP          = 1080,
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int BURST_BEATS     = H_DISP * 32 / AXI4_DATA_WIDTH,
  parameter int REQ_CNT_W       = 4
) (
  input  logic                       M_AXI_ACLK,
  input  logic                       M_AXI_ARESETN,
  input  logic                       video_vs_in,
  input  logic                       video_de_in,
  input  logic [23:0]                video_data_in,
  output logic [AXI4_DATA_WIDTH-1:0] fifo_data_out,
  output logic                       fifo_wr_en,
  input  logic                       fifo_full,
  output logic                       AXI_FULL_BURST_VALID,
  input  logic                       AXI_FULL_BURST_READY,
  output logic                       frame_start,
  output logic                       err_overflow,
  output logic                       err_line
);
  localparam int AW     = AXI4_DATA_WIDTH;
  localparam int LANES  = AW / 32;
  localparam int LANE_W = $clog2(LANES);
  localparam int BEAT_W = $clog2(BURST_BEATS + 1);
  localparam int LINE_W = $clog2(V_DISP + 1);

  localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(BURST_BEATS - 1);
  localparam logic [BEAT_W-1:0]    BEAT_MAX  = BEAT_W'(BURST_BEATS);
  localparam logic [LINE_W-1:0]    LINE_MAX  = LINE_W'(V_DISP);
  localparam logic [REQ_CNT_W-1:0] REQ_MAX   = '1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic                 vs_d1_q, de_d1_q;
  logic [23:0]          px_d1_q;
  logic [23:0]          pixel_in;
  logic [AW-33:0]       pack_q;        // earlier lanes of the word being built
  logic [LANE_W-1:0]    lane_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [LINE_W-1:0]    line_q;
  logic                 line_done_q;
  logic [REQ_CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        data_q;
  logic                 wr_en_q, fs_q, err_ovf_q, err_line_q;

  logic                 fs_evt, line_ok, word_evt, reach, short_line, hs, req_sat;
  logic [AW-1:0]        pack_d, word_d;
  logic [LANE_W-1:0]    fill_sh;

  assign fs_evt  = vs_d1_q & ~video_vs_in;
  assign line_ok = line_q < LINE_MAX;

  // A word closes on its last lane, or early when DE drops with a partial word.
  assign word_evt = ~fs_evt & de_d1_q & ((lane_q == LANE_LAST) | ~video_de_in);
  assign pack_d   = {pack_q, 8'h00, px_d1_q};
  // Shift filled lanes up to the MSB end; vacated low lanes become zero.
  assign fill_sh  = LANE_LAST - lane_q;
  assign word_d   = pack_d << {fill_sh, 5'd0};

  assign reach      = word_evt & line_ok & (beat_q == BEAT_LAST);
  assign short_line = ~fs_evt & de_d1_q & ~video_de_in & (~line_ok | (beat_q < BEAT_LAST));

`ifdef VIDEO_TO_FIFO_TEST_PATTERN_EN
  localparam int XW = $clog2(H_DISP + 1);
  logic [XW-1:0] x_q;
  logic [7:0]    frame_cnt_q;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      x_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (fs_evt) frame_cnt_q <= frame_cnt_q + 8'd1;
      x_q <= video_de_in ? x_q + 1'b1 : '0;
    end
  end

  // Frames are numbered from 0, so the first frame_start yields index 0.
  assign pixel_in = {8'(x_q), 8'(line_q), frame_cnt_q - 8'd1};
`else
  assign pixel_in = video_data_in;
`endif

  // Request FSM: VALID while any completed line is still unclaimed.
  always_comb begin
    hs        = (state_q == S_REQ) & AXI_FULL_BURST_READY;
    req_cnt_d = req_cnt_q;
    req_sat   = 1'b0;
    if (line_done_q & ~hs) begin
      if (req_cnt_q == REQ_MAX) req_sat = 1'b1;
      else                      req_cnt_d = req_cnt_q + 1'b1;
    end else if (~line_done_q & hs) begin
      req_cnt_d = req_cnt_q - 1'b1;
    end
    state_d = (req_cnt_d != '0) ? S_REQ : S_IDLE;
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      vs_d1_q     <= 1'b0;
      de_d1_q     <= 1'b0;
      px_d1_q     <= '0;
      pack_q      <= '0;
      lane_q      <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      line_done_q <= 1'b0;
      req_cnt_q   <= '0;
      state_q     <= S_IDLE;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      fs_q        <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_line_q  <= 1'b0;
    end else begin
      vs_d1_q     <= video_vs_in;
      de_d1_q     <= video_de_in;
      px_d1_q     <= pixel_in;
      fs_q        <= fs_evt;
      line_done_q <= reach;
      req_cnt_q   <= req_cnt_d;
      state_q     <= state_d;
      wr_en_q     <= word_evt & line_ok & ~fifo_full;

      if (word_evt & line_ok & ~fifo_full) data_q <= word_d;
      if ((word_evt & line_ok & fifo_full) | req_sat) err_ovf_q <= 1'b1;
      if (short_line) err_line_q <= 1'b1;

      if (fs_evt) begin
        lane_q <= '0;
        beat_q <= '0;
        line_q <= '0;
      end else if (de_d1_q) begin
        pack_q <= pack_d[AW-33:0];
        lane_q <= word_evt ? '0 : lane_q + 1'b1;
        if (~video_de_in) begin
          beat_q <= '0;
          if (line_q != LINE_MAX) line_q <= line_q + 1'b1;
        end else if (word_evt && (beat_q != BEAT_MAX)) begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  assign fifo_data_out        = data_q;
  assign fifo_wr_en           = wr_en_q;
  assign AXI_FULL_BURST_VALID = (state_q == S_REQ);
  assign frame_start          = fs_q;
  assign err_overflow         = err_ovf_q;
  assign err_line             = err_line_q;

endmodule
